// File: rtl/bus_frame_responder.sv
`default_nettype none
// bus_frame_responder -- byte-serial host frame to 32-bit memory access responder. Rev 1.0
module bus_frame_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic [7:0]  bus_a,
  input  logic [7:0]  bus_d_in,
  output logic [7:0]  bus_d_out,
  output logic [7:0]  bus_d_oe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_B2   = 4'd2,
    PH_B3   = 4'd3,
    PH_B4   = 4'd4,
    PH_MEM  = 4'd5,
    PH_R0   = 4'd6,
    PH_R1   = 4'd7,
    PH_R2   = 4'd8,
    PH_R3   = 4'd9
  } phase_t;

  phase_t      phase_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic        wr_q;
  logic [7:0]  cnt_q;

  // sync wins over every phase: it always restarts the frame at byte 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rbuf_q  <= 32'd0;
      wr_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else if (sync) begin
      addr_q[7:0]  <= bus_a;
      wdata_q[7:0] <= bus_d_in;
      phase_q      <= PH_B2;
    end else begin
      case (phase_q)
        PH_B2: begin
          addr_q[15:8]  <= bus_a;
          wdata_q[15:8] <= bus_d_in;
          phase_q       <= PH_B3;
        end
        PH_B3: begin
          addr_q[23:16]  <= bus_a;
          wdata_q[23:16] <= bus_d_in;
          phase_q        <= PH_B4;
        end
        PH_B4: begin
          addr_q[31:24]  <= bus_a;
          wdata_q[31:24] <= bus_d_in;
          phase_q        <= PH_MEM;
        end
        PH_MEM: begin
          rbuf_q  <= mem_rdata;
          wr_q    <= bus_a[0];
          phase_q <= PH_R0;
        end
        PH_R0: phase_q <= PH_R1;
        PH_R1: phase_q <= PH_R2;
        PH_R2: phase_q <= PH_R3;
        PH_R3: begin
          phase_q <= PH_IDLE;
          cnt_q   <= cnt_q + 8'd1;
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  logic rd_drive;

  // Strobes and bus drive are pure decodes of the phase/flag registers
  always_comb begin
    rd_drive  = 1'b0;
    bus_d_out = 8'h00;
    if (!wr_q) begin
      case (phase_q)
        PH_R0: begin rd_drive = 1'b1; bus_d_out = rbuf_q[31:24]; end
        PH_R1: begin rd_drive = 1'b1; bus_d_out = rbuf_q[23:16]; end
        PH_R2: begin rd_drive = 1'b1; bus_d_out = rbuf_q[15:8];  end
        PH_R3: begin rd_drive = 1'b1; bus_d_out = rbuf_q[7:0];   end
        default: ;
      endcase
    end
  end

  assign bus_d_oe  = {8{rd_drive}};
  assign mem_re    = (phase_q == PH_MEM);
  assign mem_we    = (phase_q == PH_R0) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (phase_q != PH_IDLE);
  assign frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_frame_responder.sv
`default_nettype none
// tb_bus_frame_responder -- randomized scoreboard bench with directed frame scenarios. Rev 1.0
module tb_bus_frame_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync;
  logic [7:0]  bus_a;
  logic [7:0]  bus_d_in;
  logic [7:0]  bus_d_out;
  logic [7:0]  bus_d_oe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [7:0]  frame_cnt;

  bus_frame_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .bus_a     (bus_a),
    .bus_d_in  (bus_d_in),
    .bus_d_out (bus_d_out),
    .bus_d_oe  (bus_d_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  localparam int EV_RE   = 0;
  localparam int EV_WE   = 1;
  localparam int EV_DRV  = 2;
  localparam int EV_NONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  byte_v;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  int         mon_k;
  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] exp_cnt;
  int         completions;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
  endtask

  // Monitor: every strobe or bus drive must match the oldest expected event
  initial forever begin
    @(negedge clk);
    chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    if (bus_d_oe == 8'h00) chk("idle_bus_d_out", 32'(bus_d_out), 32'd0);
    if (mem_re || mem_we || bus_d_oe != 8'h00) begin
      mon_k = mem_re ? EV_RE : (mem_we ? EV_WE : EV_DRV);
      if (sb.size() == 0) begin
        chk("event_expected", 32'(mon_k), 32'(EV_NONE));
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", 32'(mon_k), 32'(mon_e.kind));
        if (mon_e.kind == EV_RE) chk("re_addr", mem_addr, mon_e.addr);
        if (mon_e.kind == EV_WE) begin
          chk("we_addr", mem_addr, mon_e.addr);
          chk("we_wdata", mem_wdata, mon_e.wdata);
        end
        if (mon_e.kind == EV_DRV) begin
          chk("drv_oe", 32'(bus_d_oe), 32'hFF);
          chk("drv_byte", 32'(bus_d_out), 32'(mon_e.byte_v));
        end
      end
    end
  end

  task automatic step(input logic s, input logic [7:0] a, input logic [7:0] d,
                      input logic [31:0] rd, input logic exp_busy, input logic do_rst);
    sync      = s;
    bus_a     = a;
    bus_d_in  = d;
    mem_rdata = rd;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    if (do_rst) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_oe", 32'(bus_d_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
      chk("rst_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      exp_cnt = 8'd0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'($urandom), 8'($urandom), $urandom, 1'b0, 1'b0);
  endtask

  // One frame: k = cycle index (1..8) where the next sync lands, 9 = runs to completion.
  // rst_at != 0 asserts reset inside that cycle instead.
  task automatic frame(input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic wr, input int k, input logic first_busy, input int rst_at);
    int   n_ev;
    int   n_cyc;
    ev_t  e;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [31:0] rd;
    n_ev  = (rst_at != 0) ? rst_at : ((k > 8) ? 8 : k);
    n_cyc = (rst_at != 0) ? rst_at + 1 : k;
    for (int j = 1; j <= n_ev; j++) begin
      e.addr   = addr;
      e.wdata  = wdata;
      e.byte_v = 8'h00;
      if (j == 4) begin
        e.kind = EV_RE;
        sb.push_back(e);
      end else if (j == 5 && wr) begin
        e.kind = EV_WE;
        sb.push_back(e);
      end else if (j >= 5 && !wr) begin
        e.kind   = EV_DRV;
        e.byte_v = rdata[8*(8-j) +: 8];
        sb.push_back(e);
      end
    end
    for (int c = 0; c < n_cyc; c++) begin
      a  = 8'($urandom);
      d  = 8'($urandom);
      rd = $urandom;
      if (c < 4) begin
        a = addr[8*c +: 8];
        d = wdata[8*c +: 8];
      end
      if (c == 4) begin
        a  = {7'($urandom), wr};
        rd = rdata;
      end
      step(c == 0, a, d, rd, (c == 0) ? first_busy : 1'b1, (rst_at != 0) && (c == rst_at));
    end
    if (k == 9 && rst_at == 0) begin
      exp_cnt++;
      completions++;
    end
  endtask

  int   k_sel;
  logic prev_abort;

  initial begin
    rst_n     = 1'b1;
    sync      = 1'b0;
    bus_a     = 8'h00;
    bus_d_in  = 8'h00;
    mem_rdata = 32'h0;
    exp_cnt   = 8'd0;
    completions = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_oe", 32'(bus_d_oe), 32'd0);
    chk("init_cnt", 32'(frame_cnt), 32'd0);
    chk("init_addr", mem_addr, 32'd0);
    chk("init_strobes", 32'({mem_we, mem_re}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Directed write
    frame(32'h12345678, 32'hDEADBEEF, $urandom, 1'b1, 9, 1'b0, 0);
    @(negedge clk);
    chk("wr_addr_final", mem_addr, 32'h12345678);
    chk("wr_wdata_final", mem_wdata, 32'hDEADBEEF);
    chk("wr_cnt", 32'(frame_cnt), 32'd1);
    @(posedge clk);
    #1;

    // Directed read
    frame(32'h00000010, $urandom, 32'hCAFEF00D, 1'b0, 9, 1'b0, 0);
    idle(1);

    // Abort in phase 3, then a full frame
    frame($urandom, $urandom, $urandom, 1'b1, 2, 1'b0, 0);
    frame($urandom, $urandom, $urandom, 1'b0, 9, 1'b1, 0);
    idle(1);

    // Back-to-back: sync lands in the phase-9 cycle
    frame($urandom, $urandom, 32'hCAFEF00D, 1'b0, 8, 1'b0, 0);
    frame($urandom, $urandom, $urandom, 1'b1, 9, 1'b1, 0);
    @(negedge clk);
    chk("b2b_cnt", 32'(frame_cnt), 32'd4);
    @(posedge clk);
    #1;

    // Reset in phase 7 of a read
    frame($urandom, $urandom, 32'hCAFEF00D, 1'b0, 9, 1'b0, 6);
    step(1'b0, 8'($urandom), 8'($urandom), $urandom, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Random frames until the counter wraps
    completions = 0;
    prev_abort  = 1'b0;
    while (completions < 256) begin
      k_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 9;
      frame($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), k_sel, prev_abort, 0);
      prev_abort = (k_sel != 9);
      if (k_sel == 9) idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    @(negedge clk);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_frame_responder.md
BUS_FRAME_RESPONDER -- requirements
Module: bus_frame_responder

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sync  in  1  high in the cycle carrying frame byte 1.
- bus_a  in  8  host address/flag lane.
- bus_d_in  in  8  host write-data lane.
- bus_d_out  out  8  read-data lane to host.
- bus_d_oe  out  8  lane enable; all bits identical; 1 = responder drives.
- mem_addr  out  32  assembled frame address.
- mem_wdata  out  32  assembled write data.
- mem_we  out  1  one-cycle memory write strobe.
- mem_re  out  1  one-cycle memory read strobe.
- mem_rdata  in  32  memory read data; valid in the same cycle as mem_re.
- busy  out  1  high while a frame is in progress.
- frame_cnt  out  8  count of completed frames.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 SHALL hold a phase register with legal values 0 (idle) and 2..9; phase 1 is the sync cycle.
REQ-004 sync=1 at any edge SHALL capture byte 1 as follows, and SHALL set phase to 2 regardless of the current phase:
- mem_addr[7:0] <= bus_a
- mem_wdata[7:0] <= bus_d_in
REQ-005 Phases 2, 3, 4 with sync=0 SHALL capture bus_a into mem_addr bits [15:8], [23:16], [31:24] respectively, and bus_d_in into the same byte slices of mem_wdata; phase then increments.
REQ-006 Phase 5 SHALL assert mem_re=1 (decode of the phase register).
REQ-007 At the phase-5 edge, the block SHALL:
- latch mem_rdata into a 32-bit read buffer;
- latch bus_a[0] as the write flag (1=write, 0=read);
- set phase to 6.
REQ-008 mem_re SHALL be asserted on every frame reaching phase 5, including writes; read data is discarded for writes.
REQ-009 Phase 6 of a write frame SHALL assert mem_we=1 for exactly that cycle, with mem_addr/mem_wdata stable.
REQ-010 On a read frame, phases 6, 7, 8, 9 SHALL drive bus_d_out with read-buffer bits [31:24], [23:16], [15:8], [7:0] respectively, with bus_d_oe=8'hFF.
REQ-011 Outside phases 6-9 of a read frame, bus_d_out SHALL be 0 and bus_d_oe SHALL be 8'h00.
REQ-012 At the phase-9 edge, with sync=0, phase SHALL go to 0 and frame_cnt SHALL increment by 1, wrapping 255->0.
REQ-013 busy SHALL be 1 when phase is not 0.
REQ-014 In idle, sync=0 SHALL leave all state unchanged; bus bytes SHALL be ignored.
REQ-015 sync during phases 2-9 SHALL abort the current frame:
- frame_cnt SHALL not increment;
- the new byte SHALL be taken as byte 1;
- outputs decoded from the current phase in that cycle (mem_re at 5, mem_we at 6, bus drive at 6-9) SHALL still occur;
- the next cycle SHALL be phase 2, with drive and strobes released.
REQ-016 sync at the phase-9 edge SHALL start a new frame without incrementing frame_cnt.
REQ-017 mem_we and mem_re SHALL never be asserted in the same cycle.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for clk, force:
- phase=0, busy=0, write flag=0
- mem_addr=0, mem_wdata=0, read buffer=0
- mem_we=0, mem_re=0
- bus_d_out=0, bus_d_oe=0
- frame_cnt=0
REQ-019 Reset asserted mid-frame SHALL discard the frame with no strobe after the reset edge; after release, the block SHALL stay idle until sync.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write: sync with bus_a bytes 78,56,34,12, bus_d_in bytes EF,BE,AD,DE, flag 1 -> mem_addr=12345678, mem_wdata=DEADBEEF, mem_re pulse in phase 5, mem_we pulse in phase 6, bus_d_oe=0 throughout, frame_cnt=1.
- Read: address 00000010, flag 0, mem_rdata=CAFEF00D in phase 5 -> bus_d_out CA,FE,F0,0D in phases 6-9 with oe=FF, no mem_we, frame_cnt+1.
- Abort: sync again in phase 3 -> new frame from byte 1, no strobes from the first frame, frame_cnt counts only the second frame.
- Back-to-back: sync in the phase-9 cycle -> read byte 0D still driven, new frame starts, frame_cnt unchanged by the aborted frame.
- Reset: rst_n low in phase 7 of a read -> bus_d_oe=0 and busy=0 immediately, no further drive, idle after release.
- Wrap: 256 completed frames -> frame_cnt returns to 0.
